traffic_light_monitor: RTL and testbench

//  Passive checker on the lamp outputs (red/yellow/green) of the traffic light controller.

---
 rtl/traffic_light_pkg.sv | 26 ++
 rtl/traffic_light_monitor_if.sv | 28 ++
 rtl/traffic_light_monitor_decode.sv | 24 ++
 rtl/traffic_light_monitor.sv | 119 +++++++++++
 tb/tb_traffic_light_monitor.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controller and its lamp monitor:
// colour encodings, default phase durations and the legal phase order.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        COL_RED    = 2'b00,
        COL_GREEN  = 2'b01,
        COL_YELLOW = 2'b10,
        COL_NONE   = 2'b11
    } colour_e;

    localparam int DEF_RED_CYCLES    = 32;
    localparam int DEF_GREEN_CYCLES  = 20;
    localparam int DEF_YELLOW_CYCLES = 7;

    // Legal successor of each colour; NONE has no successor.
    function automatic colour_e next_colour(input colour_e c);
        case (c)
            COL_RED:    return COL_GREEN;
            COL_GREEN:  return COL_YELLOW;
            COL_YELLOW: return COL_RED;
            default:    return COL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs and status outputs of the traffic light monitor. The controller
// side (or a bench) uses master; the monitor uses slave.
interface traffic_light_monitor_if #(
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 16
);
    logic               enable;
    logic               red;
    logic               yellow;
    logic               green;
    logic [1:0]         phase;
    logic [DWELL_W-1:0] dwell;
    logic [CNT_W-1:0]   cycles_done;
    logic               err_onehot;
    logic               err_sequence;
    logic               err_timing;
    logic               error;

    modport master (
        output enable, red, yellow, green,
        input  phase, dwell, cycles_done, err_onehot, err_sequence, err_timing, error
    );

    modport slave (
        input  enable, red, yellow, green,
        output phase, dwell, cycles_done, err_onehot, err_sequence, err_timing, error
    );
endinterface

// File: rtl/traffic_light_monitor_decode.sv
// Combinational lamp decoder: exactly one lit lamp gives a valid colour,
// anything else reports invalid with colour NONE.
module traffic_lamp_decode
    import traffic_light_pkg::*;
(
    input  logic    red,
    input  logic    yellow,
    input  logic    green,
    output logic    valid,
    output colour_e colour
);

    always_comb begin
        valid  = 1'b0;
        colour = COL_NONE;
        case ({red, yellow, green})
            3'b100: begin valid = 1'b1; colour = COL_RED;    end
            3'b001: begin valid = 1'b1; colour = COL_GREEN;  end
            3'b010: begin valid = 1'b1; colour = COL_YELLOW; end
            default: begin valid = 1'b0; colour = COL_NONE;  end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the controller's lamps: tracks phase and dwell, counts
// completed cycles and raises sticky one-hot, sequence and timing errors.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = DEF_RED_CYCLES,
    parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
    parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
    parameter int DWELL_W       = 8,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    traffic_light_monitor_if.slave mon
);

    logic               cur_valid;
    colour_e            cur_colour;

    colour_e            phase_q, phase_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               partial_q, partial_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               err_onehot_q, err_onehot_d;
    logic               err_sequence_q, err_sequence_d;
    logic               err_timing_q, err_timing_d;
    logic [DWELL_W-1:0] target;

    function automatic logic [DWELL_W-1:0] phase_cycles(input colour_e c);
        case (c)
            COL_RED:    return DWELL_W'(RED_CYCLES);
            COL_GREEN:  return DWELL_W'(GREEN_CYCLES);
            COL_YELLOW: return DWELL_W'(YELLOW_CYCLES);
            default:    return '1;
        endcase
    endfunction

    traffic_lamp_decode u_decode (
        .red    (mon.red),
        .yellow (mon.yellow),
        .green  (mon.green),
        .valid  (cur_valid),
        .colour (cur_colour)
    );

    always_comb begin
        phase_d        = phase_q;
        dwell_d        = dwell_q;
        partial_d      = partial_q;
        cycles_d       = cycles_q;
        err_onehot_d   = err_onehot_q;
        err_sequence_d = err_sequence_q;
        err_timing_d   = err_timing_q;
        target         = phase_cycles(phase_q);

        if (!cur_valid) begin
            err_onehot_d = 1'b1;
            phase_d      = COL_NONE;
            dwell_d      = '0;
            partial_d    = 1'b1;
        end else if (cur_colour == phase_q) begin
            if (mon.enable) begin
                // Overrun fires once, on the sample that would exceed the full length.
                if (dwell_q == target) begin
                    err_timing_d = 1'b1;
                end
                if (dwell_q != '1) begin
                    dwell_d = dwell_q + DWELL_W'(1);
                end
            end
        end else if (phase_q != COL_NONE) begin
            if (cur_colour != next_colour(phase_q)) begin
                err_sequence_d = 1'b1;
            end
            if (!partial_q && (dwell_q != target)) begin
                err_timing_d = 1'b1;
            end
            if ((phase_q == COL_YELLOW) && (cur_colour == COL_RED)) begin
                cycles_d = cycles_q + CNT_W'(1);
            end
            phase_d   = cur_colour;
            dwell_d   = mon.enable ? DWELL_W'(1) : '0;
            partial_d = 1'b0;
        end else begin
            // First colour after reset or an invalid sample: length unknown, stays partial.
            phase_d = cur_colour;
            dwell_d = mon.enable ? DWELL_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q        <= COL_NONE;
            dwell_q        <= '0;
            partial_q      <= 1'b1;
            cycles_q       <= '0;
            err_onehot_q   <= 1'b0;
            err_sequence_q <= 1'b0;
            err_timing_q   <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            dwell_q        <= dwell_d;
            partial_q      <= partial_d;
            cycles_q       <= cycles_d;
            err_onehot_q   <= err_onehot_d;
            err_sequence_q <= err_sequence_d;
            err_timing_q   <= err_timing_d;
        end
    end

    assign mon.phase        = phase_q;
    assign mon.dwell        = dwell_q;
    assign mon.cycles_done  = cycles_q;
    assign mon.err_onehot   = err_onehot_q;
    assign mon.err_sequence = err_sequence_q;
    assign mon.err_timing   = err_timing_q;
    assign mon.error        = err_onehot_q | err_sequence_q | err_timing_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed scenarios plus randomized lamp
// traffic checked against a run-length model of the lamp rules.
module tb_traffic_light_monitor;

    logic clk = 1'b0;
    logic reset = 1'b1;

    traffic_light_monitor_if #(.DWELL_W(8), .CNT_W(16)) bus ();

    traffic_light_monitor dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int tx = 0;

    // Reference model: colour 0 red, 1 green, 2 yellow, 3 none. Dwell unbounded.
    int dur [3] = '{32, 20, 7};
    int m_phase, m_dwell, m_partial, m_cycles;
    bit m_err_oh, m_err_seq, m_err_tim;

    localparam int RED = 0, GREEN = 1, YELLOW = 2;

    function automatic logic [2:0] lamps(input int c);
        // {red, yellow, green}
        return (c == RED) ? 3'b100 : (c == GREEN) ? 3'b001 : 3'b010;
    endfunction

    function automatic int exp_dwell();
        return (m_dwell > 255) ? 255 : m_dwell;
    endfunction

    task automatic model_clear();
        m_phase = 3; m_dwell = 0; m_partial = 1; m_cycles = 0;
        m_err_oh = 0; m_err_seq = 0; m_err_tim = 0;
    endtask

    task automatic model_step(input bit en, input logic [2:0] ryg);
        int lit;
        int c;
        lit = int'(ryg[2]) + int'(ryg[1]) + int'(ryg[0]);
        c = (lit != 1) ? 3 : ryg[2] ? RED : ryg[0] ? GREEN : YELLOW;
        if (c == 3) begin
            m_err_oh = 1; m_phase = 3; m_dwell = 0; m_partial = 1;
        end else if (c == m_phase) begin
            if (en) begin
                if (m_dwell == dur[m_phase]) m_err_tim = 1;
                m_dwell++;
            end
        end else if (m_phase != 3) begin
            if (c != (m_phase + 1) % 3) m_err_seq = 1;
            if (!m_partial && m_dwell != dur[m_phase]) m_err_tim = 1;
            if (m_phase == YELLOW && c == RED) m_cycles = (m_cycles + 1) % 65536;
            m_phase = c; m_dwell = en ? 1 : 0; m_partial = 0;
        end else begin
            m_phase = c; m_dwell = en ? 1 : 0;
        end
    endtask

    task automatic drive(input bit en, input logic [2:0] ryg);
        bus.enable = en;
        {bus.red, bus.yellow, bus.green} = ryg;
        model_step(en, ryg);
        @(posedge clk);
        #1;
        tx++;
        $display("tx %0d: en=%0b ryg=%03b -> phase=%0d dwell=%0d cycles=%0d err=%0b%0b%0b",
                 tx, en, ryg, bus.phase, bus.dwell, bus.cycles_done,
                 bus.err_onehot, bus.err_sequence, bus.err_timing);
    endtask

    task automatic run(input int c, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, lamps(c));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.enable = 1'b1;
        {bus.red, bus.yellow, bus.green} = 3'b001;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        tx++;
        $display("tx %0d: reset -> phase=%0d dwell=%0d cycles=%0d err=%0b%0b%0b",
                 tx, bus.phase, bus.dwell, bus.cycles_done,
                 bus.err_onehot, bus.err_sequence, bus.err_timing);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus.phase !== 2'b11) begin miscompares++; $display("FAIL reset_phase: got %0d want 3", bus.phase); end
        vectors++; if (bus.dwell !== 8'd0) begin miscompares++; $display("FAIL reset_dwell: got %0d want 0", bus.dwell); end
        vectors++; if (bus.cycles_done !== 16'd0) begin miscompares++; $display("FAIL reset_cycles: got %0d want 0", bus.cycles_done); end
        vectors++; if ({bus.err_onehot, bus.err_sequence, bus.err_timing} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got %03b want 000", {bus.err_onehot, bus.err_sequence, bus.err_timing}); end
        vectors++; if (bus.error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %0b want 0", bus.error); end
    endtask

    task automatic test_full_cycles();
        do_reset();
        run(RED, 32);
        run(GREEN, 1);
        vectors++; if (bus.phase !== 2'b01) begin miscompares++; $display("FAIL first_green_phase: got %0d want 1", bus.phase); end
        vectors++; if (bus.dwell !== 8'd1) begin miscompares++; $display("FAIL first_green_dwell: got %0d want 1", bus.dwell); end
        run(GREEN, 19);
        run(YELLOW, 7);
        vectors++; if (bus.cycles_done !== 16'd0) begin miscompares++; $display("FAIL before_yr_cycles: got %0d want 0", bus.cycles_done); end
        run(RED, 1);
        vectors++; if (bus.cycles_done !== 16'd1) begin miscompares++; $display("FAIL first_yr_cycles: got %0d want 1", bus.cycles_done); end
        vectors++; if (bus.error !== 1'b0) begin miscompares++; $display("FAIL first_cycle_error: got %0b want 0", bus.error); end
        run(RED, 31); run(GREEN, 20); run(YELLOW, 7); run(RED, 1);
        vectors++; if (bus.cycles_done !== 16'd2) begin miscompares++; $display("FAIL second_cycle_count: got %0d want 2", bus.cycles_done); end
        vectors++; if ({bus.err_onehot, bus.err_sequence, bus.err_timing} !== 3'b000) begin
            miscompares++; $display("FAIL second_cycle_flags: got %03b want 000", {bus.err_onehot, bus.err_sequence, bus.err_timing}); end
    endtask

    task automatic test_short_green();
        do_reset();
        run(RED, 32); run(GREEN, 20); run(YELLOW, 7); run(RED, 32); run(GREEN, 19);
        vectors++; if (bus.err_timing !== 1'b0) begin miscompares++; $display("FAIL short_green_early: got %0b want 0", bus.err_timing); end
        run(YELLOW, 1);
        vectors++; if (bus.err_timing !== 1'b1) begin miscompares++; $display("FAIL short_green_timing: got %0b want 1", bus.err_timing); end
        vectors++; if ({bus.err_onehot, bus.err_sequence} !== 2'b00) begin
            miscompares++; $display("FAIL short_green_others: got %02b want 00", {bus.err_onehot, bus.err_sequence}); end
    endtask

    task automatic test_red_overrun();
        do_reset();
        run(RED, 32); run(GREEN, 20); run(YELLOW, 7); run(RED, 32);
        vectors++; if (bus.err_timing !== 1'b0 || bus.dwell !== 8'd32) begin
            miscompares++; $display("FAIL overrun_at_32: got tim=%0b dwell=%0d want tim=0 dwell=32", bus.err_timing, bus.dwell); end
        run(RED, 1);
        vectors++; if (bus.err_timing !== 1'b1 || bus.dwell !== 8'd33) begin
            miscompares++; $display("FAIL overrun_at_33: got tim=%0b dwell=%0d want tim=1 dwell=33", bus.err_timing, bus.dwell); end
        run(RED, 1);
        vectors++; if (bus.dwell !== 8'd34) begin miscompares++; $display("FAIL overrun_dwell_34: got %0d want 34", bus.dwell); end
        run(RED, 220);
        vectors++; if (bus.dwell !== 8'd254) begin miscompares++; $display("FAIL dwell_254: got %0d want 254", bus.dwell); end
        run(RED, 30);
        vectors++; if (bus.dwell !== 8'd255 || bus.phase !== 2'b00) begin
            miscompares++; $display("FAIL dwell_saturate: got dwell=%0d phase=%0d want 255 0", bus.dwell, bus.phase); end
    endtask

    task automatic test_bad_order();
        do_reset();
        run(RED, 32); run(GREEN, 20); run(YELLOW, 7); run(RED, 32); run(GREEN, 20);
        run(RED, 1);
        vectors++; if (bus.err_sequence !== 1'b1) begin miscompares++; $display("FAIL g_to_r_sequence: got %0b want 1", bus.err_sequence); end
        vectors++; if (bus.phase !== 2'b00) begin miscompares++; $display("FAIL g_to_r_phase: got %0d want 0", bus.phase); end
        vectors++; if (bus.cycles_done !== 16'd1) begin miscompares++; $display("FAIL g_to_r_cycles: got %0d want 1", bus.cycles_done); end
        vectors++; if (bus.err_timing !== 1'b0 || bus.error !== 1'b1) begin
            miscompares++; $display("FAIL g_to_r_timing: got tim=%0b error=%0b want 0 1", bus.err_timing, bus.error); end
    endtask

    task automatic test_onehot();
        do_reset();
        run(RED, 32); run(GREEN, 20); run(YELLOW, 7); run(RED, 32); run(GREEN, 10);
        drive(1'b1, 3'b101);
        vectors++; if (bus.err_onehot !== 1'b1 || bus.phase !== 2'b11 || bus.dwell !== 8'd0) begin
            miscompares++; $display("FAIL glitch: got oh=%0b phase=%0d dwell=%0d want 1 3 0", bus.err_onehot, bus.phase, bus.dwell); end
        run(GREEN, 5);
        vectors++; if (bus.phase !== 2'b01 || bus.err_sequence !== 1'b0 || bus.dwell !== 8'd5) begin
            miscompares++; $display("FAIL after_glitch: got phase=%0d seq=%0b dwell=%0d want 1 0 5", bus.phase, bus.err_sequence, bus.dwell); end
        run(YELLOW, 1);
        vectors++; if ({bus.err_sequence, bus.err_timing} !== 2'b00 || bus.phase !== 2'b10) begin
            miscompares++; $display("FAIL partial_green: got seq/tim=%02b phase=%0d want 00 2", {bus.err_sequence, bus.err_timing}, bus.phase); end
    endtask

    task automatic test_enable_hold();
        do_reset();
        run(RED, 10);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, lamps(RED));
            vectors++; if (bus.dwell !== 8'd10) begin miscompares++; $display("FAIL frozen_dwell_%0d: got %0d want 10", i, bus.dwell); end
        end
        run(RED, 22); run(GREEN, 20); run(YELLOW, 7); run(RED, 1);
        vectors++; if (bus.cycles_done !== 16'd1 || bus.error !== 1'b0) begin
            miscompares++; $display("FAIL hold_cycle: got cycles=%0d error=%0b want 1 0", bus.cycles_done, bus.error); end
        drive(1'b1, 3'b000);
        drive(1'b1, lamps(YELLOW));
        do_reset();
        vectors++; if ({bus.err_onehot, bus.err_sequence, bus.err_timing, bus.error} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_clears_flags: got %04b want 0000", {bus.err_onehot, bus.err_sequence, bus.err_timing, bus.error}); end
        vectors++; if (bus.phase !== 2'b11 || bus.cycles_done !== 16'd0 || bus.dwell !== 8'd0) begin
            miscompares++; $display("FAIL reset_clears_state: got phase=%0d cycles=%0d dwell=%0d want 3 0 0", bus.phase, bus.cycles_done, bus.dwell); end
    endtask

    task automatic test_random();
        int col;
        int len;
        int roll;
        int got;
        logic [2:0] ryg;
        bit en;
        do_reset();
        col = RED;
        for (int p = 0; p < 60; p++) begin
            roll = $urandom_range(0, 19);
            if (roll == 0) col = $urandom_range(0, 2);
            len = dur[col];
            if (roll == 1) len = len + 1;
            if (roll == 2) len = len - 1;
            if (roll == 3) len = $urandom_range(1, 40);
            got = 0;
            while (got < len) begin
                en = ($urandom_range(0, 9) != 0);
                ryg = lamps(col);
                if ($urandom_range(0, 199) == 0) ryg = 3'b111 ^ ryg;
                drive(en, ryg);
                if (en) got++;
                vectors++;
                if (bus.phase !== m_phase[1:0] || bus.dwell !== 8'(exp_dwell()) ||
                    bus.cycles_done !== 16'(m_cycles)) begin
                    miscompares++;
                    $display("FAIL rand_state tx %0d: got phase=%0d dwell=%0d cycles=%0d want %0d %0d %0d",
                             tx, bus.phase, bus.dwell, bus.cycles_done, m_phase, exp_dwell(), m_cycles);
                end
                vectors++;
                if ({bus.err_onehot, bus.err_sequence, bus.err_timing} !== {m_err_oh, m_err_seq, m_err_tim} ||
                    bus.error !== (m_err_oh | m_err_seq | m_err_tim)) begin
                    miscompares++;
                    $display("FAIL rand_flags tx %0d: got %03b err=%0b want %03b",
                             tx, {bus.err_onehot, bus.err_sequence, bus.err_timing}, bus.error,
                             {m_err_oh, m_err_seq, m_err_tim});
                end
            end
            col = (col + 1) % 3;
            if (p == 29) do_reset();
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        {bus.red, bus.yellow, bus.green} = 3'b000;
        model_clear();
        test_reset();
        test_full_cycles();
        test_short_green();
        test_red_overrun();
        test_bad_order();
        test_onehot();
        test_enable_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
